// File: rtl/rv64_ctrl_sequencer.sv
// rv64_ctrl_sequencer
//   Multi-cycle control sequencer for a small RV64 datapath. Accepts one
//   instruction per valid/ready handshake, decodes R-type ALU ops and BEQ/BNE,
//   and steps each instruction through DECODE, EXECUTE and WRITEBACK.
//
//   Build option: define RV64_CTRL_MEXT_EN to decode M-extension R-type ops
//   (funct7 = 0000001). Without it those encodings are reported as illegal.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high
//   instr          instruction word, captured on the handshake edge
//   instr_valid    instr is valid
//   instr_ready    high only in IDLE (and not while reset is held)
//   zero_flag      datapath ALU zero flag, sampled at the end of EXECUTE
//   reg_read_1     rs1 index (zero-extended)
//   reg_read_2     rs2 index (zero-extended)
//   reg_write      rd index (zero-extended)
//   reg_write_cmd  one-cycle register write strobe in WRITEBACK
//   alu_control    ALU operation code (zero-extended)
//   branch_valid   one-cycle pulse in WRITEBACK for branches
//   branch_taken   branch outcome, qualified by branch_valid
//   branch_offset  B-type immediate, qualified by branch_valid
//   instr_done     one-cycle completion pulse for every legal instruction
//   illegal_instr  one-cycle pulse in DECODE for undecodable instructions
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | ready for a new instruction
// S_DECODE  | indices/alu_control driven; illegal encodings exit here
// S_EXECUTE | datapath operates; zero_flag captured at the closing edge
// S_WRITEBACK | write strobe / branch resolution / done pulse
module rv64_ctrl_sequencer #(
  parameter int REG_IDX_W  = 8,
  parameter int ALU_CTRL_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic                  zero_flag,
  output logic [REG_IDX_W-1:0]  reg_read_1,
  output logic [REG_IDX_W-1:0]  reg_read_2,
  output logic [REG_IDX_W-1:0]  reg_write,
  output logic                  reg_write_cmd,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  branch_valid,
  output logic                  branch_taken,
  output logic [12:0]           branch_offset,
  output logic                  instr_done,
  output logic                  illegal_instr
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DECODE    = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [31:0] instr_q;
  logic [4:0]  alu_q;
  logic        illegal_q;
  logic        is_branch_q;
  logic        is_beq_q;
  logic        taken_q;

  logic [4:0]  dec_alu;
  logic        dec_illegal;
  logic        dec_branch;

  // Decode the incoming word so indices and alu_control are already valid
  // during the DECODE cycle that follows the handshake edge.
  always_comb begin
    dec_alu     = 5'd0;
    dec_illegal = 1'b1;
    dec_branch  = 1'b0;
    case (instr[6:0])
      7'b0110011: begin
        dec_illegal = 1'b0;
        case ({instr[31:25], instr[14:12]})
          {7'h00, 3'b000}: dec_alu = 5'h00;
          {7'h20, 3'b000}: dec_alu = 5'h01;
          {7'h00, 3'b001}: dec_alu = 5'h02;
          {7'h00, 3'b010}: dec_alu = 5'h03;
          {7'h00, 3'b011}: dec_alu = 5'h04;
          {7'h00, 3'b100}: dec_alu = 5'h05;
          {7'h00, 3'b101}: dec_alu = 5'h06;
          {7'h20, 3'b101}: dec_alu = 5'h07;
          {7'h00, 3'b110}: dec_alu = 5'h08;
          {7'h00, 3'b111}: dec_alu = 5'h09;
`ifdef RV64_CTRL_MEXT_EN
          // MUL..REMU occupy 0x0A..0x11 in funct3 order
          {7'h01, 3'b000}, {7'h01, 3'b001}, {7'h01, 3'b010}, {7'h01, 3'b011},
          {7'h01, 3'b100}, {7'h01, 3'b101}, {7'h01, 3'b110}, {7'h01, 3'b111}:
            dec_alu = 5'h0A + {2'b00, instr[14:12]};
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
      7'b1100011: begin
        if (instr[14:13] == 2'b00) begin
          dec_illegal = 1'b0;
          dec_branch  = 1'b1;
          dec_alu     = 5'h01;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (instr_valid) state_nxt = S_DECODE;
      S_DECODE:    state_nxt = illegal_q ? S_IDLE : S_EXECUTE;
      S_EXECUTE:   state_nxt = S_WRITEBACK;
      S_WRITEBACK: state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q     <= '0;
      alu_q       <= '0;
      illegal_q   <= 1'b0;
      is_branch_q <= 1'b0;
      is_beq_q    <= 1'b0;
      taken_q     <= 1'b0;
    end else begin
      if (state == S_IDLE && instr_valid) begin
        instr_q     <= instr;
        alu_q       <= dec_alu;
        illegal_q   <= dec_illegal;
        is_branch_q <= dec_branch;
        is_beq_q    <= ~instr[12];
      end
      if (state == S_EXECUTE)
        taken_q <= is_beq_q ? zero_flag : ~zero_flag;
    end
  end

  // Strobes are also masked by reset so an abort during the cycle that
  // would have been WRITEBACK produces no side effects.
  always_comb begin
    instr_ready   = 1'b0;
    reg_write_cmd = 1'b0;
    branch_valid  = 1'b0;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      S_IDLE:      instr_ready = ~reset;
      S_DECODE:    illegal_instr = illegal_q & ~reset;
      S_WRITEBACK: begin
        instr_done    = ~reset;
        reg_write_cmd = ~is_branch_q & (instr_q[11:7] != 5'd0) & ~reset;
        branch_valid  = is_branch_q & ~reset;
      end
      default: ;
    endcase
  end

  assign reg_read_1    = REG_IDX_W'(instr_q[19:15]);
  assign reg_read_2    = REG_IDX_W'(instr_q[24:20]);
  assign reg_write     = REG_IDX_W'(instr_q[11:7]);
  assign alu_control   = ALU_CTRL_W'(alu_q);
  assign branch_taken  = taken_q;
  assign branch_offset = {instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};

endmodule

// File: tb/tb_rv64_ctrl_sequencer.sv
module tb_rv64_ctrl_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        zero_flag;
  logic [7:0]  reg_read_1, reg_read_2, reg_write, alu_control;
  logic        reg_write_cmd, branch_valid, branch_taken, instr_done, illegal_instr;
  logic [12:0] branch_offset;

  int n_total = 0;
  int n_bad   = 0;

  rv64_ctrl_sequencer dut (
    .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .zero_flag(zero_flag),
    .reg_read_1(reg_read_1), .reg_read_2(reg_read_2), .reg_write(reg_write),
    .reg_write_cmd(reg_write_cmd), .alu_control(alu_control),
    .branch_valid(branch_valid), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .instr_done(instr_done),
    .illegal_instr(illegal_instr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: mnemonic table keyed by {funct7,funct3}, searched linearly.
  logic [9:0] r_keys [10] = '{
    {7'h00,3'd0}, {7'h20,3'd0}, {7'h00,3'd1}, {7'h00,3'd2}, {7'h00,3'd3},
    {7'h00,3'd4}, {7'h00,3'd5}, {7'h20,3'd5}, {7'h00,3'd6}, {7'h00,3'd7}};

  function automatic void model(input logic [31:0] w, output bit ill,
                                output bit br, output bit beq, output int alu);
    ill = 1; br = 0; beq = 0; alu = 0;
    if (w[6:0] == 7'h33) begin
      for (int i = 0; i < 10; i++)
        if (r_keys[i] == {w[31:25], w[14:12]}) begin ill = 0; alu = i; end
`ifdef RV64_CTRL_MEXT_EN
      if (w[31:25] == 7'h01) begin ill = 0; alu = 10 + int'(w[14:12]); end
`endif
    end else if (w[6:0] == 7'h63 && (w[14:12] == 3'd0 || w[14:12] == 3'd1)) begin
      ill = 0; br = 1; beq = (w[14:12] == 3'd0); alu = 1;
    end
  endfunction

  task automatic run_instr(input logic [31:0] w, input bit zf);
    bit ill, br, beq;
    int alu;
    int guard = 0;
    logic [12:0] off;
    model(w, ill, br, beq, alu);
    off = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    @(negedge clock);
    while (!instr_ready && guard < 20) begin @(negedge clock); guard++; end
    chk("ready_idle", 32'(instr_ready), 1);
    instr = w; instr_valid = 1'b1; zero_flag = 1'($urandom);
    @(negedge clock);                       // DECODE
    instr = $urandom; instr_valid = 1'b1;   // must be ignored while busy
    chk("dec_ready", 32'(instr_ready), 0);
    chk("dec_rr1", 32'(reg_read_1), 32'(w[19:15]));
    chk("dec_rr2", 32'(reg_read_2), 32'(w[24:20]));
    chk("dec_wr", 32'(reg_write), 32'(w[11:7]));
    chk("dec_illegal", 32'(illegal_instr), 32'(ill));
    chk("dec_wcmd", 32'(reg_write_cmd), 0);
    chk("dec_done", 32'(instr_done), 0);
    if (!ill) chk("dec_alu", 32'(alu_control), 32'(alu));
    if (ill) begin
      @(negedge clock);
      instr_valid = 1'b0;
      chk("ill_ready", 32'(instr_ready), 1);
      chk("ill_done", 32'(instr_done), 0);
      chk("ill_pulse", 32'(illegal_instr), 0);
      return;
    end
    @(negedge clock);                       // EXECUTE
    zero_flag = zf;
    chk("ex_ready", 32'(instr_ready), 0);
    chk("ex_wcmd", 32'(reg_write_cmd), 0);
    chk("ex_done", 32'(instr_done), 0);
    chk("ex_bvalid", 32'(branch_valid), 0);
    chk("ex_rr1", 32'(reg_read_1), 32'(w[19:15]));
    chk("ex_alu", 32'(alu_control), 32'(alu));
    @(negedge clock);                       // WRITEBACK
    zero_flag = ~zf;
    chk("wb_wcmd", 32'(reg_write_cmd), 32'(!br && w[11:7] != 5'd0));
    chk("wb_done", 32'(instr_done), 1);
    chk("wb_bvalid", 32'(branch_valid), 32'(br));
    chk("wb_wr", 32'(reg_write), 32'(w[11:7]));
    chk("wb_ready", 32'(instr_ready), 0);
    if (br) begin
      chk("wb_taken", 32'(branch_taken), 32'(beq ? zf : !zf));
      chk("wb_offset", 32'(branch_offset), 32'(off));
    end
    @(negedge clock);                       // back to IDLE
    instr_valid = 1'b0;
    chk("post_ready", 32'(instr_ready), 1);
    chk("post_wcmd", 32'(reg_write_cmd), 0);
    chk("post_done", 32'(instr_done), 0);
    chk("post_bvalid", 32'(branch_valid), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(instr_ready), 0);
    chk({tag, "_wcmd"}, 32'(reg_write_cmd), 0);
    chk({tag, "_done"}, 32'(instr_done), 0);
    chk({tag, "_bvalid"}, 32'(branch_valid), 0);
    chk({tag, "_ill"}, 32'(illegal_instr), 0);
    chk({tag, "_idx"}, {8'h0, reg_read_1, reg_read_2, reg_write}, 0);
    chk({tag, "_alu"}, 32'(alu_control), 0);
    chk({tag, "_taken"}, 32'(branch_taken), 0);
    chk({tag, "_off"}, 32'(branch_offset), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int k;
    reset = 1'b1; instr = '0; instr_valid = 1'b0; zero_flag = 1'b0;
    repeat (3) @(negedge clock);
    chk_all_zero("rst");
    reset = 1'b0;
    #1 chk("rst_release_ready", 32'(instr_ready), 1);

    run_instr(32'h002081B3, 1'b0);   // ADD x3,x1,x2
    run_instr(32'h407302B3, 1'b1);   // SUB x5,x6,x7
    run_instr(32'h00208463, 1'b1);   // BEQ taken
    run_instr(32'h00208463, 1'b0);   // BEQ not taken
    run_instr(32'h00209463, 1'b0);   // BNE taken
    run_instr(32'h00208033, 1'b0);   // ADD x0 (no write)
    run_instr(32'hFFFFFFFF, 1'b0);   // illegal
    run_instr(32'h022081B3, 1'b0);   // MUL (build-dependent)

    // Reset during EXECUTE aborts the instruction.
    @(negedge clock);
    instr = 32'h002081B3; instr_valid = 1'b1;
    @(negedge clock);                // DECODE
    instr_valid = 1'b0;
    @(negedge clock);                // EXECUTE
    reset = 1'b1;
    @(negedge clock);                // would-be WRITEBACK
    chk_all_zero("abort");
    @(negedge clock);
    reset = 1'b0;
    #1 chk("abort_release_ready", 32'(instr_ready), 1);

    for (int n = 0; n < 60; n++) begin
      w = $urandom;
      k = $urandom_range(0, 4);
      case (k)
        0: begin w[6:0] = 7'h33; {w[31:25], w[14:12]} = r_keys[$urandom_range(0, 9)]; end
        1: begin w[6:0] = 7'h63; w[14:12] = 3'($urandom_range(0, 2)); end
        2: ;
        3: begin w[6:0] = 7'h33; w[31:25] = 7'h01; end
        default: begin w[6:0] = 7'h33; {w[31:25], w[14:12]} = r_keys[$urandom_range(0, 9)]; w[11:7] = 5'd0; end
      endcase
      run_instr(w, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
